// File: rtl/maxnet_pkg.sv
// Shared types and helpers for the Maxnet sequencer and its neuron bank.
package maxnet_pkg;
    localparam int FP_W   = 32;
    localparam int N_NEUR = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } fp_op_t;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_SUM    = 3'd3;
    localparam logic [2:0] S_UPD    = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;
    localparam logic [2:0] S_ABORT  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [FP_W-1:0] FP_ZERO = '0;

    // Strictly positive: sign clear and not +0.
    function automatic logic is_pos(input logic [FP_W-1:0] fp);
        return !fp[FP_W-1] && (fp[FP_W-2:0] != '0);
    endfunction
endpackage

// File: rtl/maxnet_neuron_bank.sv
// Current/next activation registers with relu write port, commit, load and
// positive-count / single-winner index.
module maxnet_neuron_bank
    import maxnet_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         load_i,
    input  logic [N_NEUR-1:0][FP_W-1:0] load_val_i,
    input  logic                         commit_i,
    input  logic                         wr_en_i,
    input  logic [1:0]                   wr_idx_i,
    input  logic [FP_W-1:0]              wr_val_i,
    output logic [N_NEUR-1:0][FP_W-1:0] cur_o,
    output logic [2:0]                   pos_cnt_o,
    output logic [1:0]                   pos_idx_o
);
    logic [N_NEUR-1:0][FP_W-1:0] cur_q, nxt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_q <= '0;
            nxt_q <= '0;
        end else begin
            if (load_i)
                cur_q <= load_val_i;
            else if (commit_i)
                cur_q <= nxt_q;
            // relu also folds -0 to +0
            if (wr_en_i)
                nxt_q[wr_idx_i] <= is_pos(wr_val_i) ? wr_val_i : FP_ZERO;
        end
    end

    always_comb begin
        pos_cnt_o = '0;
        pos_idx_o = '0;
        for (int i = 0; i < N_NEUR; i++) begin
            if (is_pos(cur_q[i])) begin
                pos_cnt_o = pos_cnt_o + 3'd1;
                pos_idx_o = 2'(i);
            end
        end
    end

    assign cur_o = cur_q;
endmodule

// File: rtl/maxnet_sequencer.sv
// Runs the 4-neuron Maxnet recurrence on an external FP32 unit over req/ack,
// 15 ops per iteration (3 for the sum, 3 per neuron update).
module maxnet_sequencer
    import maxnet_pkg::*;
#(
    parameter int MAX_ITER = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [FP_W-1:0] eps,
    input  logic [FP_W-1:0] a1,
    input  logic [FP_W-1:0] a2,
    input  logic [FP_W-1:0] a3,
    input  logic [FP_W-1:0] a4,
    output logic            busy,
    output logic            finish,
    output logic            overflow,
    output logic [FP_W-1:0] out,
    output logic [1:0]      win_idx,
    output logic            fp_req,
    output logic [1:0]      fp_op,
    output logic [FP_W-1:0] fp_x,
    output logic [FP_W-1:0] fp_y,
    input  logic            fp_ack,
    input  logic [FP_W-1:0] fp_z,
    input  logic            fp_ovf
);
    localparam int            IW       = $clog2(MAX_ITER + 1);
    localparam logic [IW-1:0] ITER_LIM = IW'(MAX_ITER);

    logic [2:0]      state_q, state_d;
    logic [3:0]      opc_q, opc_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic [FP_W-1:0] eps_q, eps_d, s_q, s_d;
    logic            req_q, req_d, ovf_q, ovf_d;
    fp_op_t          op_q, op_d;
    logic [FP_W-1:0] x_q, x_d, y_q, y_d, out_q, out_d;
    logic [1:0]      win_q, win_d;

    logic [N_NEUR-1:0][FP_W-1:0] cur;
    logic [2:0]      pos_cnt;
    logic [1:0]      pos_idx, wr_idx, n_j;
    logic            load, commit, wr_en, ack_ok;
    logic [3:0]      n_op, n_k, c_k;
    fp_op_t          nop;
    logic [FP_W-1:0] nx, ny, s_now;

    maxnet_neuron_bank u_bank (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (load),
        .load_val_i ({a4, a3, a2, a1}),
        .commit_i   (commit),
        .wr_en_i    (wr_en),
        .wr_idx_i   (wr_idx),
        .wr_val_i   (fp_z),
        .cur_o      (cur),
        .pos_cnt_o  (pos_cnt),
        .pos_idx_o  (pos_idx)
    );

    // Operands for the next op, built from fp_z on the ack cycle so the
    // following op can be presented back-to-back.
    always_comb begin
        n_op  = (state_q == S_CHECK) ? 4'd0 : opc_q + 4'd1;
        n_k   = n_op - 4'd3;
        n_j   = 2'(n_k / 4'd3);
        s_now = (opc_q == 4'd2) ? fp_z : s_q;
        nop   = OP_ADD;
        nx    = fp_z;
        ny    = cur[n_j];
        case (n_op)
            4'd0: begin nx = cur[0]; ny = cur[1]; end
            4'd1: ny = cur[2];
            4'd2: ny = cur[3];
            default: begin
                case (n_k % 4'd3)
                    4'd0:    begin nop = OP_SUB; nx = s_now; end
                    4'd1:    begin nop = OP_MUL; nx = eps_q; ny = fp_z; end
                    default: begin nx = cur[n_j]; ny = fp_z; end
                endcase
            end
        endcase
    end

    assign c_k    = opc_q - 4'd3;
    assign wr_idx = 2'(c_k / 4'd3);
    assign ack_ok = req_q && fp_ack;

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        iter_d  = iter_q;
        eps_d   = eps_q;
        s_d     = s_q;
        req_d   = req_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        out_d   = out_q;
        win_d   = win_q;
        ovf_d   = ovf_q;
        load    = 1'b0;
        commit  = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_LOAD;
                out_d   = FP_ZERO;
                win_d   = '0;
                ovf_d   = 1'b0;
            end
            S_LOAD: begin
                load    = 1'b1;
                eps_d   = eps;
                iter_d  = '0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (pos_cnt <= 3'd1) begin
                    state_d = S_DONE;
                    out_d   = (pos_cnt == 3'd1) ? cur[pos_idx] : FP_ZERO;
                    win_d   = (pos_cnt == 3'd1) ? pos_idx : 2'd0;
                    ovf_d   = 1'b0;
                end else if (iter_q == ITER_LIM) begin
                    state_d = S_ABORT;
                end else begin
                    state_d = S_SUM;
                    opc_d   = '0;
                    req_d   = 1'b1;
                    op_d    = nop;
                    x_d     = nx;
                    y_d     = ny;
                end
            end
            S_SUM, S_UPD: if (ack_ok) begin
                if (fp_ovf) begin
                    state_d = S_ABORT;
                    req_d   = 1'b0;
                end else begin
                    if (opc_q <= 4'd2)
                        s_d = fp_z;
                    wr_en = (opc_q >= 4'd3) && (c_k % 4'd3 == 4'd2);
                    if (opc_q == 4'd14) begin
                        state_d = S_COMMIT;
                        req_d   = 1'b0;
                    end else begin
                        opc_d = opc_q + 4'd1;
                        op_d  = nop;
                        x_d   = nx;
                        y_d   = ny;
                        if (opc_q == 4'd2)
                            state_d = S_UPD;
                    end
                end
            end
            S_COMMIT: begin
                commit  = 1'b1;
                iter_d  = iter_q + 1'b1;
                state_d = S_CHECK;
            end
            S_ABORT: begin
                ovf_d   = 1'b1;
                out_d   = FP_ZERO;
                win_d   = '0;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            opc_q   <= '0;
            iter_q  <= '0;
            eps_q   <= '0;
            s_q     <= '0;
            req_q   <= 1'b0;
            op_q    <= OP_ADD;
            x_q     <= '0;
            y_q     <= '0;
            out_q   <= '0;
            win_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            iter_q  <= iter_d;
            eps_q   <= eps_d;
            s_q     <= s_d;
            req_q   <= req_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            out_q   <= out_d;
            win_q   <= win_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign finish   = (state_q == S_DONE);
    assign overflow = ovf_q;
    assign out      = out_q;
    assign win_idx  = win_q;
    assign fp_req   = req_q;
    assign fp_op    = op_q;
    assign fp_x     = x_q;
    assign fp_y     = y_q;
endmodule

// File: tb/tb_maxnet_sequencer.sv
// Directed bench for maxnet_sequencer: behavioural FP32 unit with 1-cycle ack
// and an independent FP32 Maxnet reference model.
module tb_maxnet_sequencer;
    localparam int MI = 8;
    localparam logic [31:0] EPS  = 32'hBE4CCCCD;
    localparam logic [31:0] P1   = 32'h461C3FA7;
    localparam logic [31:0] N1   = 32'hC61C3FA7;
    localparam logic [31:0] ONE  = 32'h3F800000;
    localparam logic [31:0] TWO  = 32'h40000000;

    logic clk, rst, start;
    logic [31:0] eps, a1, a2, a3, a4;
    logic busy, finish, overflow, fp_req, fp_ack, fp_ovf;
    logic [31:0] out, fp_x, fp_y, fp_z;
    logic [1:0] win_idx, fp_op;

    int total = 0;
    int bad = 0;

    int r_cyc, r_nack;
    logic r_fin, r_ovf, r_req_after, r_busy1;
    logic [31:0] r_out, r_x0, r_y0;
    logic [1:0] r_win;

    logic [31:0] m_out;
    logic [1:0] m_win;
    logic m_ovf;
    int m_iter;

    maxnet_sequencer #(.MAX_ITER(MI)) dut (
        .clk(clk), .rst(rst), .start(start), .eps(eps),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .busy(busy), .finish(finish), .overflow(overflow),
        .out(out), .win_idx(win_idx),
        .fp_req(fp_req), .fp_op(fp_op), .fp_x(fp_x), .fp_y(fp_y),
        .fp_ack(fp_ack), .fp_z(fp_z), .fp_ovf(fp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] x);
        logic [63:0] b;
        if (x[30:23] == 8'd0) b = {x[31], 63'd0};
        else b = {x[31], ({3'b000, x[30:23]} + 11'd896), x[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    // double -> single with round-to-nearest-even; exact for +,-,* of singles
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [52:0] m;
        logic [24:0] k;
        logic up;
        int ef;
        b = $realtobits(r);
        if (b[62:52] == 11'd0) return {b[63], 31'd0};
        m  = {1'b1, b[51:0]};
        up = (m[28:0] > 29'h1000_0000) || ((m[28:0] == 29'h1000_0000) && m[29]);
        k  = {1'b0, m[52:29]} + {24'd0, up};
        ef = int'(b[62:52]) - 896;
        if (k[24]) begin ef++; k = k >> 1; end
        if (ef >= 255) return {b[63], 8'hFF, 23'd0};
        if (ef <= 0) return {b[63], 31'd0};
        return {b[63], ef[7:0], k[22:0]};
    endfunction

    function automatic logic [31:0] fpu(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        real rx, ry, rz;
        rx = f2r(x);
        ry = f2r(y);
        case (op)
            2'd0:    rz = rx + ry;
            2'd1:    rz = rx - ry;
            default: rz = rx * ry;
        endcase
        return r2f(rz);
    endfunction

    function automatic logic pos(input logic [31:0] x);
        return !x[31] && (x[30:0] != 31'd0);
    endfunction

    task automatic model(input logic [31:0] e, input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] v3);
        logic [31:0] c[4];
        logic [31:0] n[4];
        logic [31:0] s, t;
        int np, idx;
        c[0] = v0; c[1] = v1; c[2] = v2; c[3] = v3;
        m_iter = 0;
        for (int g = 0; g < 1000; g++) begin
            np = 0; idx = 0;
            for (int i = 0; i < 4; i++) if (pos(c[i])) begin np++; idx = i; end
            if (np <= 1) begin
                m_ovf = 1'b0;
                m_out = (np == 1) ? c[idx] : 32'd0;
                m_win = (np == 1) ? 2'(idx) : 2'd0;
                return;
            end
            if (m_iter == MI) begin
                m_ovf = 1'b1; m_out = 32'd0; m_win = 2'd0;
                return;
            end
            s = fpu(2'd0, c[0], c[1]);
            s = fpu(2'd0, s, c[2]);
            s = fpu(2'd0, s, c[3]);
            for (int j = 0; j < 4; j++) begin
                t = fpu(2'd1, s, c[j]);
                t = fpu(2'd2, e, t);
                t = fpu(2'd0, c[j], t);
                n[j] = pos(t) ? t : 32'd0;
            end
            c = n;
            m_iter++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Start a run and act as the FP unit (ack one cycle after each request)
    // until finish, or until stop_ack acks have been given with fp_req high.
    task automatic run(input logic [31:0] e, input logic [31:0] v0, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] v3,
                       input int ovf_at, input int busy_start_at, input int stop_ack);
        int age;
        logic inj;
        age = 0; inj = 1'b0;
        r_fin = 1'b0; r_cyc = 0; r_nack = 0; r_req_after = 1'b0; r_busy1 = 1'b0;
        r_out = 32'd0; r_win = 2'd0; r_ovf = 1'b0; r_x0 = 32'd0; r_y0 = 32'd0;
        @(negedge clk);
        eps = e; a1 = v0; a2 = v1; a3 = v2; a4 = v3;
        start = 1'b1; fp_ack = 1'b0; fp_ovf = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (cyc == 1) r_busy1 = busy;
            if (cyc == 2) begin
                eps = 32'hDEADBEEF; a1 = 32'hDEADBEEF; a2 = 32'h12345678;
                a3 = 32'h3F000000; a4 = 32'h3F000000;
            end
            start = (cyc == busy_start_at);
            fp_ack = 1'b0; fp_ovf = 1'b0;
            if (finish) begin
                r_fin = 1'b1; r_cyc = cyc; r_out = out; r_win = win_idx; r_ovf = overflow;
                break;
            end
            if (inj && fp_req) r_req_after = 1'b1;
            if (stop_ack != 0 && r_nack == stop_ack && fp_req) begin
                start = 1'b0;
                return;
            end
            if (fp_req) begin
                if (age == 1) begin
                    fp_ack = 1'b1;
                    fp_z = fpu(fp_op, fp_x, fp_y);
                    r_nack++;
                    if (r_nack == 1) begin r_x0 = fp_x; r_y0 = fp_y; end
                    if (r_nack == ovf_at) begin fp_ovf = 1'b1; inj = 1'b1; end
                    age = 0;
                end else age = 1;
            end else age = 0;
            @(negedge clk);
        end
        start = 1'b0; fp_ack = 1'b0; fp_ovf = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; eps = '0; a1 = '0; a2 = '0; a3 = '0; a4 = '0;
        fp_ack = 1'b0; fp_z = '0; fp_ovf = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finish", 32'(finish), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_fp_req", 32'(fp_req), 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_win", 32'(win_idx), 32'd0);
        chk("rst_fp_xy_op", fp_x | fp_y | 32'(fp_op), 32'd0);
        rst = 1'b0;

        // two positives among large values
        model(EPS, P1, N1, 32'h3FA66666, N1);
        run(EPS, P1, N1, 32'h3FA66666, N1, 0, 0, 0);
        chk("t1_finish", 32'(r_fin), 32'd1);
        chk("t1_busy", 32'(r_busy1), 32'd1);
        chk("t1_first_x", r_x0, P1);
        chk("t1_first_y", r_y0, N1);
        chk("t1_out", r_out, m_out);
        chk("t1_win", 32'(r_win), 32'(m_win));
        chk("t1_ovf", 32'(r_ovf), 32'd0);
        chk("t1_win_const", 32'(r_win), 32'd0);
        chk("t1_acks", 32'(r_nack), 32'(m_iter * 15));
        chk("t1_cycles", 32'(r_cyc), 32'(3 + 32 * m_iter));

        // single positive: no FP ops, finish 3 cycles after start
        run(EPS, P1, N1, 32'd0, N1, 0, 0, 0);
        chk("t2_cycles", 32'(r_cyc), 32'd3);
        chk("t2_acks", 32'(r_nack), 32'd0);
        chk("t2_out", r_out, P1);
        chk("t2_win", 32'(r_win), 32'd0);
        chk("t2_ovf", 32'(r_ovf), 32'd0);

        // {1,2,0,0}: 3 iterations, start pulse while busy must be ignored
        model(EPS, ONE, TWO, 32'd0, 32'd0);
        chk("t3_model_iter", 32'(m_iter), 32'd3);
        run(EPS, ONE, TWO, 32'd0, 32'd0, 0, 10, 0);
        chk("t3_acks", 32'(r_nack), 32'd45);
        chk("t3_cycles", 32'(r_cyc), 32'd99);
        chk("t3_win", 32'(r_win), 32'd1);
        chk("t3_out", r_out, m_out);
        chk("t3_out_range", 32'(r_out > 32'h3FD00000 && r_out < 32'h3FD20000), 32'd1);
        chk("t3_ovf", 32'(r_ovf), 32'd0);

        // symmetric inputs never resolve: iteration limit abort
        run(EPS, ONE, ONE, 32'd0, 32'd0, 0, 0, 0);
        chk("t4_acks", 32'(r_nack), 32'(MI * 15));
        chk("t4_cycles", 32'(r_cyc), 32'(4 + 32 * MI));
        chk("t4_ovf", 32'(r_ovf), 32'd1);
        chk("t4_out", r_out, 32'd0);
        chk("t4_win", 32'(r_win), 32'd0);

        // FP overflow on the 5th ack
        run(EPS, ONE, TWO, 32'd0, 32'd0, 5, 0, 0);
        chk("t5_cycles", 32'(r_cyc), 32'd14);
        chk("t5_acks", 32'(r_nack), 32'd5);
        chk("t5_ovf", 32'(r_ovf), 32'd1);
        chk("t5_out", r_out, 32'd0);
        chk("t5_win", 32'(r_win), 32'd0);
        chk("t5_no_req_after", 32'(r_req_after), 32'd0);
        @(negedge clk);
        chk("t5_ovf_held", 32'(overflow), 32'd1);
        chk("t5_finish_pulse", 32'(finish), 32'd0);

        // reset during UPD with a request outstanding
        run(EPS, ONE, TWO, 32'd0, 32'd0, 0, 4, 5);
        chk("t6_req_before_rst", 32'(fp_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_req", 32'(fp_req), 32'd0);
        chk("t6_outs", out | fp_x | fp_y | 32'(fp_op) | 32'(win_idx), 32'd0);
        chk("t6_flags", 32'({finish, overflow}), 32'd0);
        rst = 1'b0;
        run(EPS, ONE, TWO, 32'd0, 32'd0, 0, 20, 0);
        chk("t6_acks", 32'(r_nack), 32'd45);
        chk("t6_cycles", 32'(r_cyc), 32'd99);
        chk("t6_out", r_out, m_out);
        chk("t6_win", 32'(r_win), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
